// File: rtl/halut_pkg.sv
// Shared sizing for the HALUT LUT/accumulate stage: codebook geometry, data widths
// and the LUT address type used by the accumulator and its testbench.
package halut_pkg;

  localparam int K             = 16;
  localparam int C             = 32;
  localparam int DataTypeWidth = 16;

  // Summing C sign-extended entries needs log2(C) guard bits to never wrap.
  function automatic int acc_width(input int data_width, input int num_codebooks);
    return data_width + $clog2(num_codebooks);
  endfunction

  localparam int AccWidth     = acc_width(DataTypeWidth, C);
  localparam int KAddrWidth   = $clog2(K);
  localparam int CAddrWidth   = $clog2(C);
  localparam int LutAddrWidth = $clog2(C * K);

  typedef logic [LutAddrWidth-1:0] lut_addr_t;

endpackage

// File: rtl/halut_result_fifo.sv
// Small result FIFO with synchronous reset. A push while full is accepted only when
// a pop frees the head in the same cycle; otherwise it is ignored by this block.
module halut_result_fifo #(
  parameter int Depth = 2,
  parameter int Width = 21
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem_q [Depth];
  logic [Width-1:0]    mem_d [Depth];
  logic [PtrWidth-1:0] wptr_q, wptr_d;
  logic [PtrWidth-1:0] rptr_q, rptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + PtrWidth'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrWidth'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates visibility of every entry.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/scm.sv
// Standard-cell memory: one synchronous write port and one combinational read port A.
// A read of the address being written in the same cycle returns the old contents.
module scm #(
  parameter int NumWords  = 512,
  parameter int DataWidth = 16,
  parameter int AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o
);

  logic [DataWidth-1:0] mem_q [NumWords];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];

endmodule

// File: rtl/halut_lut_accumulator.sv
// Looks up LUT[c][k] for each incoming encoding and sums C of them into one row result,
// which is handed to a small valid/ready FIFO. The input side never stalls.
module halut_lut_accumulator
  import halut_pkg::*;
#(
  parameter int FifoDepth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     decoder_i,
  input  logic [CAddrWidth-1:0]    c_addr_i,
  input  logic [KAddrWidth-1:0]    k_addr_i,
  input  logic                     valid_i,
  input  lut_addr_t                lut_waddr_i,
  input  logic [DataTypeWidth-1:0] lut_wdata_i,
  input  logic                     lut_we_i,
  output logic [AccWidth-1:0]      result_o,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic                     overflow_o,
  output logic [CAddrWidth-1:0]    row_cnt_o
);

  // Handshake: a result transfers on any clock edge where result_valid_o & result_ready_i;
  // result_o is held stable while valid and not ready. There is no backpressure on valid_i.

  localparam logic [CAddrWidth-1:0] RowLast = CAddrWidth'(C - 1);

  logic                     v1_q, v1_d;
  logic [CAddrWidth-1:0]    c1_q, c1_d;
  logic [KAddrWidth-1:0]    k1_q, k1_d;
  logic [AccWidth-1:0]      acc_q, acc_d;
  logic [CAddrWidth-1:0]    row_cnt_q, row_cnt_d;
  logic                     push_q, push_d;
  logic [AccWidth-1:0]      push_data_q, push_data_d;
  logic                     overflow_q, overflow_d;

  lut_addr_t                lut_raddr;
  logic [DataTypeWidth-1:0] lut_rdata;
  logic [AccWidth-1:0]      lut_sext;
  logic [AccWidth-1:0]      acc_add;
  logic                     fifo_full, fifo_empty, fifo_pop;

  assign lut_raddr = {c1_q, k1_q};
  assign lut_sext  = {{(AccWidth - DataTypeWidth){lut_rdata[DataTypeWidth-1]}}, lut_rdata};
  assign acc_add   = acc_q + lut_sext;

  scm #(
    .NumWords (C * K),
    .DataWidth(DataTypeWidth),
    .AddrWidth(LutAddrWidth)
  ) u_lut (
    .clk_i    (clk_i),
    .we_i     (lut_we_i),
    .waddr_i  (lut_waddr_i),
    .wdata_i  (lut_wdata_i),
    .raddr_a_i(lut_raddr),
    .rdata_a_o(lut_rdata)
  );

  always_comb begin
    v1_d        = v1_q;
    c1_d        = c1_q;
    k1_d        = k1_q;
    acc_d       = acc_q;
    row_cnt_d   = row_cnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (!decoder_i) begin
      // Partial row is abandoned, including an encoding still sitting in S1.
      v1_d      = 1'b0;
      acc_d     = '0;
      row_cnt_d = '0;
    end else begin
      v1_d = valid_i;
      if (valid_i) begin
        c1_d = c_addr_i;
        k1_d = k_addr_i;
      end
      if (v1_q) begin
        if (row_cnt_q == RowLast) begin
          push_d      = 1'b1;
          push_data_d = acc_add;
          acc_d       = '0;
          row_cnt_d   = '0;
        end else begin
          acc_d     = acc_add;
          row_cnt_d = row_cnt_q + CAddrWidth'(1);
        end
      end
    end
    // A completed row pushed into a full FIFO with no pop is lost.
    overflow_d = overflow_q | (push_q & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q        <= 1'b0;
      c1_q        <= '0;
      k1_q        <= '0;
      acc_q       <= '0;
      row_cnt_q   <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      c1_q        <= c1_d;
      k1_q        <= k1_d;
      acc_q       <= acc_d;
      row_cnt_q   <= row_cnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
    end
  end

  halut_result_fifo #(
    .Depth(FifoDepth),
    .Width(AccWidth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_q),
    .data_i (push_data_q),
    .pop_i  (fifo_pop),
    .data_o (result_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign result_valid_o = ~fifo_empty;
  assign fifo_pop       = result_valid_o & result_ready_i;
  assign overflow_o     = overflow_q;
  assign row_cnt_o      = row_cnt_q;

endmodule

// File: tb/tb_halut_lut_accumulator.sv
// Bench for halut_lut_accumulator: table of whole-row vectors, hand sequences for the
// multi-cycle corners, and randomized rows scored against a plain sum-of-lookups model.
module tb_halut_lut_accumulator;
  import halut_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_i;
  logic                     decoder_i;
  logic [CAddrWidth-1:0]    c_addr_i;
  logic [KAddrWidth-1:0]    k_addr_i;
  logic                     valid_i;
  lut_addr_t                lut_waddr_i;
  logic [DataTypeWidth-1:0] lut_wdata_i;
  logic                     lut_we_i;
  logic [AccWidth-1:0]      result_o;
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic                     overflow_o;
  logic [CAddrWidth-1:0]    row_cnt_o;

  halut_lut_accumulator #(.FifoDepth(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .decoder_i     (decoder_i),
    .c_addr_i      (c_addr_i),
    .k_addr_i      (k_addr_i),
    .valid_i       (valid_i),
    .lut_waddr_i   (lut_waddr_i),
    .lut_wdata_i   (lut_wdata_i),
    .lut_we_i      (lut_we_i),
    .result_o      (result_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .overflow_o    (overflow_o),
    .row_cnt_o     (row_cnt_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  int                  vectors     = 0;
  int                  miscompares = 0;
  int                  pops        = 0;
  bit                  rand_ready  = 1'b0;
  int                  lut_m [C*K];
  logic [AccWidth-1:0] exp_q [$];

  typedef struct {
    int lut_mode;
    int k_mode;
    int exp_sum;
  } row_vec_t;

  row_vec_t vecs [6];

  function automatic int lut_val(input int mode, input int c, input int k);
    case (mode)
      0:       return c * 16 + k;
      1:       return -32768;
      2:       return 1;
      3:       return k - 8;
      default: return 32767;
    endcase
  endfunction

  function automatic int k_sel(input int mode, input int c);
    case (mode)
      0:       return c % 16;
      1:       return 15;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    if (rand_ready) result_ready_i = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic lut_write(input int addr, input int v);
    lut_we_i    = 1'b1;
    lut_waddr_i = lut_addr_t'(addr);
    lut_wdata_i = DataTypeWidth'(v);
    step();
    lut_we_i    = 1'b0;
    lut_m[addr] = v;
  endtask

  task automatic fill_lut(input int mode);
    for (int c = 0; c < C; c++)
      for (int k = 0; k < K; k++)
        lut_write(c * K + k, lut_val(mode, c, k));
  endtask

  task automatic send(input int c, input int k);
    valid_i  = 1'b1;
    c_addr_i = CAddrWidth'(c);
    k_addr_i = KAddrWidth'(k);
    step();
    valid_i  = 1'b0;
  endtask

  // Full row with k chosen by mode; returns the model sum of the looked-up entries.
  task automatic send_row(input int kmode, output longint sum);
    sum = 0;
    for (int c = 0; c < C; c++) begin
      sum += lut_m[c * K + k_sel(kmode, c)];
      send(c, k_sel(kmode, c));
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_i && result_valid_o && result_ready_i) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_pop", $signed(result_o), 0);
        if (result_o == '0) begin
          miscompares++;
          $display("FAIL unexpected_pop: got pop with empty expected queue, expected none");
        end
      end else begin
        check("pop_result", $signed(result_o), $signed(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    longint sum;
    int     pops0;

    rst_i          = 1'b1;
    decoder_i      = 1'b1;
    c_addr_i       = '0;
    k_addr_i       = '0;
    valid_i        = 1'b0;
    lut_waddr_i    = '0;
    lut_wdata_i    = '0;
    lut_we_i       = 1'b0;
    result_ready_i = 1'b1;

    vecs[0] = '{lut_mode: 0, k_mode: 0, exp_sum: 8176};
    vecs[1] = '{lut_mode: 1, k_mode: 2, exp_sum: -1048576};
    vecs[2] = '{lut_mode: 2, k_mode: 1, exp_sum: 32};
    vecs[3] = '{lut_mode: 0, k_mode: 1, exp_sum: 8416};
    vecs[4] = '{lut_mode: 3, k_mode: 2, exp_sum: -256};
    vecs[5] = '{lut_mode: 4, k_mode: 0, exp_sum: 1048544};

    step();
    step();
    check("rst_valid", result_valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_row_cnt", row_cnt_o, 0);
    rst_i = 1'b0;
    step();

    // Table-driven whole rows with latency check (T1, T2 and variants).
    for (int i = 0; i < 6; i++) begin
      fill_lut(vecs[i].lut_mode);
      send_row(vecs[i].k_mode, sum);
      exp_q.push_back(AccWidth'(sum));
      check("lat_t1", result_valid_o, 0);
      step();
      check("lat_t2", result_valid_o, 0);
      step();
      check("lat_t3_valid", result_valid_o, 1);
      check("lat_t3_result", $signed(result_o), vecs[i].exp_sum);
      step();
      step();
    end

    // T5: write the address S2 is reading in that same cycle.
    fill_lut(2);
    for (int c = 0; c < C - 1; c++) send(c, 0);
    exp_q.push_back(AccWidth'(32));
    valid_i  = 1'b1;
    c_addr_i = CAddrWidth'(C - 1);
    k_addr_i = '0;
    step();
    valid_i     = 1'b0;
    lut_we_i    = 1'b1;
    lut_waddr_i = lut_addr_t'((C - 1) * K);
    lut_wdata_i = DataTypeWidth'(100);
    step();
    lut_we_i = 1'b0;
    lut_m[(C - 1) * K] = 100;
    step();
    check("coll_old_value", $signed(result_o), 32);
    step();
    send_row(2, sum);
    exp_q.push_back(AccWidth'(sum));
    step();
    step();
    check("coll_new_value", $signed(result_o), 131);
    step();
    step();

    // T3: three rows into a stalled 2-deep FIFO.
    result_ready_i = 1'b0;
    fill_lut(2);
    send_row(0, sum);
    exp_q.push_back(AccWidth'(sum));
    send_row(0, sum);
    exp_q.push_back(AccWidth'(sum));
    step();
    step();
    check("ovf_before", overflow_o, 0);
    send_row(0, sum);
    step();
    step();
    check("ovf_after", overflow_o, 1);
    check("ovf_valid_held", result_valid_o, 1);
    check("ovf_head_held", $signed(result_o), 32);
    pops0 = pops;
    result_ready_i = 1'b1;
    for (int n = 0; n < 20; n++) step();
    check("ovf_pop_count", pops - pops0, 2);
    check("ovf_drained", result_valid_o, 0);
    check("ovf_exp_left", exp_q.size(), 0);

    // T6: reset mid-row with one FIFO entry (overflow still set from T3).
    result_ready_i = 1'b0;
    send_row(0, sum);
    exp_q.push_back(AccWidth'(sum));
    for (int c = 0; c < 5; c++) send(c, 0);
    step();
    step();
    check("t6_pre_valid", result_valid_o, 1);
    rst_i = 1'b1;
    step();
    check("t6_valid", result_valid_o, 0);
    check("t6_result", result_o, 0);
    check("t6_overflow", overflow_o, 0);
    check("t6_row_cnt", row_cnt_o, 0);
    rst_i = 1'b0;
    exp_q.delete();
    result_ready_i = 1'b1;
    step();

    // T4: decoder_i dropped with a partial row in flight.
    fill_lut(0);
    for (int c = 0; c < 10; c++) send(c, c % 16);
    check("t4_partial_cnt", row_cnt_o, 9);
    decoder_i = 1'b0;
    step();
    check("t4_flushed_cnt", row_cnt_o, 0);
    decoder_i = 1'b1;
    send_row(0, sum);
    exp_q.push_back(AccWidth'(sum));
    step();
    step();
    check("t4_fresh_sum", $signed(result_o), 8176);
    step();
    step();

    // Randomized rows: random LUT, random c/k, random gaps, random ready.
    for (int a = 0; a < C * K; a++) lut_write(a, int'($urandom_range(0, 65535)) - 32768);
    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      sum = 0;
      for (int e = 0; e < C; e++) begin
        int c, k, gaps;
        c    = $urandom_range(0, C - 1);
        k    = $urandom_range(0, K - 1);
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) step();
        sum += lut_m[c * K + k];
        send(c, k);
      end
      exp_q.push_back(AccWidth'(sum));
    end
    rand_ready     = 1'b0;
    result_ready_i = 1'b1;
    for (int n = 0; n < 50 && (exp_q.size() != 0 || result_valid_o); n++) step();
    check("rand_exp_left", exp_q.size(), 0);
    check("rand_drained", result_valid_o, 0);
    check("rand_no_overflow", overflow_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
